// File: rtl/tdm_demux4.sv
// tdm_demux4: receive side of a four-slot time-division multiplexed channel.
// It follows the frame marker through a HUNT/SYNC state machine. Each slot sample
// is collected into a shadow register. All four channel outputs are then
// published together when the frame completes.
// Optional feature: define TDM_DEMUX_PARITY_EN to add a fifth parity slot
// (bit 0 of that slot = XOR of every bit of the four channel samples).
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             frame,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [1:0]       slot,
    output logic             frame_valid,
    output logic             sync_err,
    output logic             par_err
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int SW = 3;
`else
    localparam int SW = 2;
`endif
    // Index of the final slot of a frame: the parity slot when it exists.
    localparam logic [SW-1:0] LAST_SLOT = (SW == 3) ? SW'(4) : SW'(3);

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [WIDTH-1:0] sh0, sh1, sh2;
`ifdef TDM_DEMUX_PARITY_EN
    logic [WIDTH-1:0] sh3;
    logic             parity_ok;
`endif

    // Decoded per-sample actions.
    logic load_sh0;     // marker sample: start of a (possibly re-aligned) frame
    logic load_mid;     // interior slot sample into sh[slot]
    logic last_sample;  // final slot of an aligned frame
    logic update_y;
    logic frame_valid_d;
    logic sync_err_d;
    logic par_err_d;

    // State register: alignment state and slot counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            slot_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values, independent of statement order.
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    // Next-state logic: frame alignment and slot advance.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latches.
        state_d = state_q;
        slot_d  = slot_q;
        if (en) begin
            unique case (state_q)
                HUNT: begin
                    if (frame) begin
                        state_d = SYNC;
                        slot_d  = SW'(1);
                    end
                end
                SYNC: begin
                    if (frame) begin
                        // Normal start or premature marker: both re-align here.
                        slot_d = SW'(1);
                    end else if (slot_q == '0) begin
                        // Marker missing where a frame must start: lose lock.
                        state_d = HUNT;
                        slot_d  = '0;
                    end else if (slot_q == LAST_SLOT) begin
                        slot_d = '0;
                    end else begin
                        slot_d = slot_q + SW'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = '0;
                end
            endcase
        end
    end

    // Output decode: capture strobes and next values of the pulse outputs.
    always_comb begin
        load_sh0    = en && frame;
        load_mid    = en && (state_q == SYNC) && !frame &&
                      (slot_q != '0) && (slot_q != LAST_SLOT);
        last_sample = en && (state_q == SYNC) && !frame && (slot_q == LAST_SLOT);
        sync_err_d  = en && (state_q == SYNC) &&
                      (frame ? (slot_q != '0) : (slot_q == '0));
`ifdef TDM_DEMUX_PARITY_EN
        parity_ok     = (din[0] == ^{sh0, sh1, sh2, sh3});
        update_y      = last_sample && parity_ok;
        par_err_d     = last_sample && !parity_ok;
`else
        update_y      = last_sample;
        par_err_d     = 1'b0;
`endif
        frame_valid_d = update_y;
    end

    // Datapath: shadow capture, frame publish and registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: shadows are reset too, so a frame cut short by reset
            // leaves no stale sample behind.
            sh0         <= '0;
            sh1         <= '0;
            sh2         <= '0;
`ifdef TDM_DEMUX_PARITY_EN
            sh3         <= '0;
`endif
            y0          <= '0;
            y1          <= '0;
            y2          <= '0;
            y3          <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= frame_valid_d;
            sync_err    <= sync_err_d;
            if (load_sh0) begin
                sh0 <= din;
            end
            if (load_mid) begin
                case (slot_q)
                    SW'(1): sh1 <= din;
                    SW'(2): sh2 <= din;
`ifdef TDM_DEMUX_PARITY_EN
                    SW'(3): sh3 <= din;
`endif
                    default: ;
                endcase
            end
            if (update_y) begin
                y0 <= sh0;
                y1 <= sh1;
                y2 <= sh2;
`ifdef TDM_DEMUX_PARITY_EN
                y3 <= sh3;
`else
                y3 <= din;
`endif
            end
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    // Registered parity-error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= par_err_d;
        end
    end
`else
    assign par_err = par_err_d;
`endif

    // In the parity build the internal slot 4 reads 4[1:0] = 0 on the port.
    assign slot = slot_q[1:0];

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed bench for tdm_demux4. The default build checks the
// four-slot frame. With TDM_DEMUX_PARITY_EN defined, it checks the parity slot
// at WIDTH=4.
module tb_tdm_demux4;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int W = 4;
`else
    localparam int W = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] din = '0;
    logic         frame = 1'b0;
    logic [W-1:0] y0, y1, y2, y3;
    logic [1:0]   slot;
    logic         frame_valid, sync_err, par_err;

    int checks = 0;
    int errors = 0;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .frame(frame),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .slot(slot),
        .frame_valid(frame_valid), .sync_err(sync_err), .par_err(par_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one sample, then sample the outputs 1 ns after the edge.
    task automatic cycle(input logic e, input logic f, input logic [W-1:0] d);
        en = e; frame = f; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_y(input string tag, input logic [4*W-1:0] exp);
        check(tag, 32'({y0, y1, y2, y3}), 32'(exp));
    endtask

    task automatic check_pulses(input string tag, input logic fv, input logic se, input logic pe);
        check(tag, {29'd0, frame_valid, sync_err, par_err}, {29'd0, fv, se, pe});
    endtask

    initial begin
        rst = 1'b1;
        cycle(0, 0, '0);
        cycle(1, 1, '1);
        check_y("reset_y", '0);
        check("reset_slot", 32'(slot), 0);
        check_pulses("reset_pulses", 0, 0, 0);
        rst = 1'b0;

`ifndef TDM_DEMUX_PARITY_EN
        // Basic frame 1,0,1,1.
        cycle(1, 1, 1'b1);
        check("f1_slot1", 32'(slot), 1);
        cycle(1, 0, 1'b0);
        cycle(1, 0, 1'b1);
        check("f1_slot3", 32'(slot), 3);
        check_pulses("f1_nopulse", 0, 0, 0);
        cycle(1, 0, 1'b1);
        check_y("f1_y", 4'b1011);
        check_pulses("f1_valid", 1, 0, 0);
        check("f1_slot_wrap", 32'(slot), 0);
        cycle(0, 0, 1'b0);
        check_pulses("f1_valid_one_cycle", 0, 0, 0);
        check_y("f1_y_hold", 4'b1011);

        // Frame 1,1,0,1 with a two-cycle en gap after slot 1.
        cycle(1, 1, 1'b1);
        cycle(1, 0, 1'b1);
        cycle(0, 1, 1'b0);
        cycle(0, 0, 1'b0);
        check("gap_slot_hold", 32'(slot), 2);
        check_pulses("gap_nopulse", 0, 0, 0);
        cycle(1, 0, 1'b0);
        cycle(1, 0, 1'b1);
        check_y("gap_y", 4'b1101);
        check_pulses("gap_valid", 1, 0, 0);

        // Frame 1,1,1,1, then a premature marker at slot 2.
        cycle(1, 1, 1'b1);
        cycle(1, 0, 1'b1);
        cycle(1, 0, 1'b1);
        cycle(1, 0, 1'b1);
        check_y("ones_y", 4'b1111);
        cycle(1, 1, 1'b0);
        cycle(1, 0, 1'b0);
        cycle(1, 1, 1'b0);
        check_pulses("premature_err", 0, 1, 0);
        check("premature_slot", 32'(slot), 1);
        check_y("premature_y_hold", 4'b1111);
        cycle(1, 0, 1'b1);
        check_pulses("premature_err_one_cycle", 0, 0, 0);
        cycle(1, 0, 1'b0);
        cycle(1, 0, 1'b0);
        check_y("realign_y", 4'b0100);
        check_pulses("realign_valid", 1, 0, 0);

        // Missing marker at slot 0 -> HUNT; samples ignored until a marker.
        cycle(1, 0, 1'b1);
        check_pulses("missing_err", 0, 1, 0);
        check("hunt_slot", 32'(slot), 0);
        cycle(1, 0, 1'b1);
        cycle(1, 0, 1'b0);
        check_pulses("hunt_quiet", 0, 0, 0);
        check("hunt_slot_hold", 32'(slot), 0);
        cycle(1, 1, 1'b1);
        check("hunt_lock_slot", 32'(slot), 1);
        cycle(1, 0, 1'b1);
        cycle(1, 0, 1'b1);
        cycle(1, 0, 1'b0);
        check_y("hunt_resume_y", 4'b1110);
        check_pulses("hunt_resume_valid", 1, 0, 0);

        // Reset at slot 2 of a partial frame.
        cycle(1, 1, 1'b0);
        cycle(1, 0, 1'b1);
        check("pre_reset_slot", 32'(slot), 2);
        rst = 1'b1;
        cycle(1, 0, 1'b1);
        check_y("midreset_y", 4'b0000);
        check("midreset_slot", 32'(slot), 0);
        check_pulses("midreset_pulses", 0, 0, 0);
        rst = 1'b0;
        cycle(1, 1, 1'b0);
        cycle(1, 0, 1'b1);
        cycle(1, 0, 1'b1);
        cycle(1, 0, 1'b1);
        check_y("post_reset_y", 4'b0111);
        check_pulses("post_reset_valid", 1, 0, 0);
`else
        // Frame 3,1,0,0 with good parity (XOR of all bits = 1).
        cycle(1, 1, 4'h3);
        cycle(1, 0, 4'h1);
        cycle(1, 0, 4'h0);
        cycle(1, 0, 4'h0);
        check("par_slot4_port", 32'(slot), 0);
        check_pulses("par_before_check", 0, 0, 0);
        cycle(1, 0, 4'h1);
        check_y("par_good_y", 16'h3100);
        check_pulses("par_good_valid", 1, 0, 0);
        check("par_slot_wrap", 32'(slot), 0);

        // Frame 7,2,0,0 (parity 0) sent with parity 1 -> error, y holds.
        cycle(1, 1, 4'h7);
        cycle(1, 0, 4'h2);
        cycle(1, 0, 4'h0);
        cycle(1, 0, 4'h0);
        cycle(1, 0, 4'h1);
        check_pulses("par_bad_err", 0, 0, 1);
        check_y("par_bad_y_hold", 16'h3100);
        cycle(0, 0, 4'h0);
        check_pulses("par_err_one_cycle", 0, 0, 0);

        // Same frame with correct parity 0 -> update.
        cycle(1, 1, 4'h7);
        cycle(1, 0, 4'h2);
        cycle(1, 0, 4'h0);
        cycle(1, 0, 4'h0);
        cycle(1, 0, 4'h0);
        check_y("par_fix_y", 16'h7200);
        check_pulses("par_fix_valid", 1, 0, 0);

        // Marker arriving in slot 4 is premature.
        cycle(1, 1, 4'h1);
        cycle(1, 0, 4'h1);
        cycle(1, 0, 4'h1);
        cycle(1, 0, 4'h1);
        cycle(1, 1, 4'h0);
        check_pulses("par_slot4_premature", 0, 1, 0);
        check("par_slot4_realign", 32'(slot), 1);
        check_y("par_slot4_y_hold", 16'h7200);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
